sm_skid_register: RTL



---
 rtl/sm_skid_register.sv | 105 ++++++++++
 1 files changed

// File: rtl/sm_skid_register.sv
// Two-entry elastic pipeline register (main + skid) with registered valid/ready,
// synchronous flush and an occupancy output.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   EMPTY | nothing held, m_valid=0, s_ready=1
//   BUSY  | main entry valid, skid empty, s_ready=1
//   FULL  | main and skid both valid, s_ready=0
module sm_skid_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             s_ready_q;
    logic             m_valid_q;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // flush wins; handshakes seen this cycle never touch buffer state
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (s_valid) begin
                        load_main = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (s_valid && m_ready) begin
                        load_main = 1'b1;
                    end else if (s_valid) begin
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (m_ready) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (m_ready) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = BUSY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Output flags are computed from the next state so they leave flops directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            main_q    <= RESET_VALUE;
            skid_q    <= RESET_VALUE;
        end else begin
            state     <= state_nxt;
            s_ready_q <= (state_nxt != FULL);
            m_valid_q <= (state_nxt != EMPTY);
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : s_data;
            end
            if (load_skid) begin
                skid_q <= s_data;
            end
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;
    assign level   = state;

endmodule
